// File: rtl/day7_pkg.sv
// Shared types and constants for the day-7 row sequencer.
package day7_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StDrain,
        StDone
    } seq_state_t;

    localparam int unsigned DefWidth = 141;
    localparam int unsigned DefRows  = 142;
    localparam int unsigned HIT_W    = 8;
    localparam int unsigned TOTAL_W  = 64;

endpackage

// File: rtl/day7_hit_accum.sv
// Outstanding-row counter and 64-bit splitter-hit accumulator.
module day7_hit_accum
    import day7_pkg::*;
#(
    parameter int unsigned CntW = 9
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               issue_i,
    input  logic               hit_valid_i,
    input  logic [HIT_W-1:0]   hit_count_i,
    output logic               outstanding_zero_o,
    output logic [TOTAL_W-1:0] total_o
);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               hit_ok;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign hit_ok = hit_valid_i && (cnt_q != '0);

    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        if (clear_i) begin
            cnt_d   = '0;
            total_d = '0;
        end else begin
            if (issue_i) begin
                cnt_d = cnt_d + CntW'(1);
            end
            if (hit_ok) begin
                cnt_d   = cnt_d - CntW'(1);
                total_d = total_q + TOTAL_W'(hit_count_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            total_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

    // Reports the post-update count so DRAIN can leave on the final response's cycle.
    assign outstanding_zero_o = (cnt_d == '0);
    assign total_o            = total_q;

endmodule

// File: rtl/day7_row_sequencer.sv
// Row fetch / issue / drain sequencer for the day-7 beam-splitter datapath.
// Optional: define DAY7_SKIP_EMPTY_EN to skip all-zero rows other than row 0.
module day7_row_sequencer
    import day7_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned ROWS   = DefRows,
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [WIDTH-1:0]   mem_rd_data,
    output logic               dp_valid,
    input  logic               dp_ready,
    output logic [WIDTH-1:0]   dp_row,
    output logic               dp_first,
    output logic               dp_last,
    input  logic               hit_valid,
    input  logic [HIT_W-1:0]   hit_count,
    output logic [TOTAL_W-1:0] splitters_hit
);

    seq_state_t state_q, state_d;

    logic [ADDR_W-1:0] row_idx_q, row_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              dp_valid_q, dp_valid_d;
    logic [WIDTH-1:0]  dp_row_q, dp_row_d;
    logic              dp_first_q, dp_first_d;
    logic              dp_last_q, dp_last_d;

    logic start_ok;
    logic issue;
    logic is_last;
    logic skip_row;
    logic out_zero;

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign issue    = (state_q == StIssue) && dp_ready;
    assign is_last  = (row_idx_q == ADDR_W'(ROWS - 1));

`ifdef DAY7_SKIP_EMPTY_EN
    assign skip_row = (row_idx_q != '0) && (mem_rd_data == '0);
`else
    assign skip_row = 1'b0;
`endif

    day7_hit_accum #(
        .CntW (ADDR_W + 1)
    ) u_hit_accum (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (start_ok),
        .issue_i            (issue),
        .hit_valid_i        (hit_valid),
        .hit_count_i        (hit_count),
        .outstanding_zero_o (out_zero),
        .total_o            (splitters_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            row_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            dp_valid_q <= 1'b0;
            dp_row_q   <= '0;
            dp_first_q <= 1'b0;
            dp_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            dp_valid_q <= dp_valid_d;
            dp_row_q   <= dp_row_d;
            dp_first_q <= dp_first_d;
            dp_last_q  <= dp_last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StFetch;
                    row_idx_d = '0;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                if (skip_row) begin
                    row_idx_d = row_idx_q + ADDR_W'(1);
                    state_d   = is_last ? StDrain : StFetch;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (dp_ready) begin
                    row_idx_d = row_idx_q + ADDR_W'(1);
                    state_d   = is_last ? StDrain : StFetch;
                end
            end
            StDrain: begin
                if (out_zero) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        busy_d     = (state_d != StIdle) && (state_d != StDone);
        done_d     = (state_d == StDone);
        rd_en_d    = (state_d == StFetch);
        rd_addr_d  = row_idx_d;
        dp_valid_d = (state_d == StIssue);
        dp_row_d   = dp_row_q;
        dp_first_d = dp_first_q;
        dp_last_d  = dp_last_q;
        if ((state_q == StWait) && (state_d == StIssue)) begin
            dp_row_d   = mem_rd_data;
            dp_first_d = (row_idx_q == '0);
            dp_last_d  = is_last;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign dp_valid    = dp_valid_q;
    assign dp_row      = dp_row_q;
    assign dp_first    = dp_first_q;
    assign dp_last     = dp_last_q;

endmodule

// File: tb/tb_day7_row_sequencer.sv
// Directed bench for day7_row_sequencer on a 4-row, 8-column grid.
module tb_day7_row_sequencer;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int AW = 2;

`ifdef DAY7_SKIP_EMPTY_EN
    localparam int ExpHs   = 3;
    localparam int BaseLen = 14;
`else
    localparam int ExpHs   = 4;
    localparam int BaseLen = 15;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, mem_rd_en, dp_valid, dp_first, dp_last;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_data = '0;
    logic          dp_ready = 1'b1;
    logic [W-1:0]  dp_row;
    logic          hit_valid = 1'b0;
    logic [7:0]    hit_count = '0;
    logic [63:0]   splitters_hit;

    day7_row_sequencer #(
        .WIDTH  (W),
        .ROWS   (R),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .dp_valid      (dp_valid),
        .dp_ready      (dp_ready),
        .dp_row        (dp_row),
        .dp_first      (dp_first),
        .dp_last       (dp_last),
        .hit_valid     (hit_valid),
        .hit_count     (hit_count),
        .splitters_hit (splitters_hit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] cnt;
    } resp_t;

    typedef struct {
        int          lat;
        int          stall;
        bit          mid;
        logic [63:0] total;
        int          hs;
        int          len;
    } vec_t;

    resp_t q[$];
    int    lat = 2;
    int    stall_len = 0;
    int    stall_cnt = 0;
    int    stall_seen = 0;
    int    stab_err = 0;
    bit    prev_stall = 0;
    int    hs_cnt = 0;
    int    first_valid_cyc = -1;
    int    done_cyc = -1;
    bit    prev_done = 0;
    bit    flush = 0;
    bit    inject = 0;
    int    checks = 0;
    int    errors = 0;

    function automatic logic [7:0] rom_word(input logic [AW-1:0] a);
        case (a)
            2'd0:    return 8'h10;
            2'd1:    return 8'h10;
            2'd2:    return 8'h00;
            default: return 8'h28;
        endcase
    endfunction

    // Hit counts {0,1,0,2} keyed by the row contents seen on the handshake.
    function automatic logic [7:0] hit_for_row();
        if (dp_last) return 8'd2;
        if (!dp_first && dp_row == 8'h10) return 8'd1;
        return 8'd0;
    endfunction

    // Memory, datapath responder and observers all act on the falling edge.
    always @(negedge clk) begin
        bit stalling;
        if (mem_rd_en) mem_rd_data = rom_word(mem_rd_addr);
        hit_valid = 1'b0;
        hit_count = '0;
        if (flush) begin
            q.delete();
        end else if (q.size() > 0 && q[0].due == cyc) begin
            hit_valid = 1'b1;
            hit_count = q[0].cnt;
            void'(q.pop_front());
        end
        if (inject) begin
            hit_valid = 1'b1;
            hit_count = 8'd5;
        end
        stalling = dp_valid && !dp_first && dp_row == 8'h10 && stall_cnt < stall_len;
        dp_ready = !stalling;
        if (prev_stall && dp_row != 8'h10) stab_err++;
        if (stalling) begin
            stall_cnt++;
            stall_seen++;
        end
        prev_stall = stalling;
        if (dp_valid && dp_ready) begin
            hs_cnt++;
            q.push_back('{due: cyc + lat, cnt: hit_for_row()});
        end
        if (dp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done && !prev_done) done_cyc = cyc;
        prev_done = done;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
        chk({tag, "_dp_valid"}, 64'(dp_valid), 64'd0);
        chk({tag, "_dp_row"}, 64'(dp_row), 64'd0);
        chk({tag, "_dp_first"}, 64'(dp_first), 64'd0);
        chk({tag, "_dp_last"}, 64'(dp_last), 64'd0);
        chk({tag, "_total"}, splitters_hit, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        bit got;
        @(negedge clk);
        lat = v.lat;
        stall_len = v.stall;
        stall_cnt = 0;
        stall_seen = 0;
        stab_err = 0;
        prev_stall = 0;
        hs_cnt = 0;
        first_valid_cyc = -1;
        done_cyc = -1;
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("done_cleared", 64'(done), 64'd0);
        chk("rd_en_after_start", 64'(mem_rd_en), 64'd1);
        chk("rd_addr_row0", 64'(mem_rd_addr), 64'd0);
        chk("total_cleared", splitters_hit, 64'd0);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            start = v.mid && (cyc == t + 8);
            if (done) got = 1;
        end
        start = 1'b0;
        chk("done_within_budget", 64'(got), 64'd1);
        @(negedge clk);
        chk("total", splitters_hit, v.total);
        chk("done_sticky", 64'(done), 64'd1);
        chk("busy_low_in_done", 64'(busy), 64'd0);
        chk("handshakes", 64'(hs_cnt), 64'(v.hs));
        chk("run_length", 64'(done_cyc - t), 64'(v.len));
        chk("first_valid_latency", 64'(first_valid_cyc - t), 64'd3);
        chk("stall_cycles_row1", 64'(stall_seen), 64'(v.stall));
        chk("row_stable_in_stall", 64'(stab_err), 64'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   n_issue;
        bit   prev_v;
        vecs[0] = '{lat: 2, stall: 0, mid: 0, total: 64'd3, hs: ExpHs, len: BaseLen};
        vecs[1] = '{lat: 2, stall: 5, mid: 0, total: 64'd3, hs: ExpHs, len: BaseLen + 5};
        vecs[2] = '{lat: 3, stall: 0, mid: 0, total: 64'd3, hs: ExpHs, len: BaseLen + 1};
        vecs[3] = '{lat: 2, stall: 0, mid: 1, total: 64'd3, hs: ExpHs, len: BaseLen};
        vecs[4] = '{lat: 2, stall: 0, mid: 0, total: 64'd3, hs: ExpHs, len: BaseLen};

        flush = 1;
        repeat (3) @(negedge clk);
        chk_reset("por");
        flush = 0;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Responses with nothing outstanding must not touch the total.
        @(negedge clk);
        inject = 1;
        repeat (2) @(negedge clk);
        inject = 0;
        repeat (2) @(negedge clk);
        chk("stray_hit_total", splitters_hit, 64'd3);
        chk("stray_hit_done", 64'(done), 64'd1);

        // Asynchronous reset while the third offered row is in ISSUE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_issue = 0;
        prev_v = 0;
        for (int i = 0; i < 100 && n_issue < 3; i++) begin
            @(negedge clk);
            if (dp_valid && !prev_v) n_issue++;
            prev_v = dp_valid;
        end
        chk("reached_third_issue", 64'(n_issue), 64'd3);
        #1 rst_n = 1'b0;
        #1 chk_reset("async");
        flush = 1;
        repeat (2) @(negedge clk);
        flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/day7_row_sequencer.md
# day7_row_sequencer

Controller that sequences the day-7 beam-splitter datapath through a puzzle grid. It fetches one grid row per step from a row memory, presents it to the beam-propagation datapath over a valid/ready handshake, collects each row's splitter-hit count, and accumulates the 64-bit total. It sits between the grid ROM and the datapath and owns the top-level `start`/`done` sequencing.

## Interface
Parameters:
- `WIDTH`, 141: grid columns; row word width.
- `ROWS`, 142: grid rows, including row 0.
- `ADDR_W`, 8: row address width; must satisfy 2^ADDR_W ≥ ROWS.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; starts a run. Honoured only in IDLE or DONE.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is entered.
- `done`  out  1  high in DONE; sticky until the next accepted `start`.
- `mem_rd_en`  out  1  row read strobe.
- `mem_rd_addr`  out  ADDR_W  row index.
- `mem_rd_data`  in  WIDTH  row bitmap, valid exactly 1 cycle after `mem_rd_en`. Row 0: bit set = 'S'. Other rows: bit set = '^'.
- `dp_valid`  out  1  row offered to the datapath.
- `dp_ready`  in  1  datapath accepts the row.
- `dp_row`  out  WIDTH  row bitmap.
- `dp_first`  out  1  the offered row is row 0 (seed beam).
- `dp_last`  out  1  the offered row is row ROWS-1.
- `hit_valid`  in  1  one pulse per accepted row, at any latency, in order.
- `hit_count`  in  8  splitters hit in that row.
- `splitters_hit`  out  64  running total.

## Operation
- FSM states: IDLE, FETCH, WAIT, ISSUE, DRAIN, DONE.
- IDLE/DONE + `start` → FETCH. Row index is cleared to 0, `splitters_hit` is cleared, the outstanding counter is cleared, and `done` is cleared.
- FETCH: `mem_rd_en`=1 with `mem_rd_addr`=row index for exactly one cycle → WAIT.
- WAIT: capture `mem_rd_data` into `dp_row`, and set `dp_first`/`dp_last` from the row index → ISSUE.
- ISSUE: `dp_valid`=1. `dp_row`, `dp_first` and `dp_last` are held stable until `dp_ready`.
  - On handshake: outstanding +1 and row index +1.
  - If the row index was ROWS-1 → DRAIN, otherwise → FETCH.
- DRAIN: wait until outstanding == 0 → DONE.
- On every `hit_valid`: `splitters_hit` += zero-extended `hit_count`, outstanding −1. This happens in any busy state, including in the same cycle as an ISSUE handshake; the net outstanding change is then 0.
- `splitters_hit` wraps modulo 2^64.
- `hit_valid` while outstanding == 0 is a protocol error: it is ignored and the counter does not go negative.
- `start` while busy is ignored.
- `rst_n` low at any time (mid-run included) immediately returns the FSM to IDLE with all outputs at their reset values. An in-flight read or handshake is abandoned.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `dp_valid`=0, `dp_row`=0, `dp_first`=0, `dp_last`=0, `splitters_hit`=0.
- `start` at cycle t → `mem_rd_en` at t+1, data at t+2, `dp_valid` at t+3.
- Per row: 3 cycles with `dp_ready` tied high; each cycle of backpressure adds one cycle.
- Last `hit_valid` at cycle u, with DRAIN reached → `done`=1 at u+1, and `busy` falls in the same cycle.
- All outputs are registered; no combinational input→output paths.

## Configuration
- `DAY7_SKIP_EMPTY_EN` defined:
  - A fetched row with index ≠ 0 and `mem_rd_data`==0 is not offered. WAIT goes directly to FETCH, or to DRAIN if it was the last row.
  - The row index advances, outstanding is unchanged, and the total is unchanged.
  - If the last row is skipped, `dp_last` is never asserted for that run.
- Not defined: every row is offered, including all-zero rows.

## Structure
- Package `day7_pkg`:
  - FSM state enum `seq_state_t`.
  - Default `WIDTH`/`ROWS` constants.
  - `HIT_W`=8 and `TOTAL_W`=64.
- Sub-module `day7_hit_accum` holds the outstanding counter and the 64-bit accumulator. Its inputs are issue, `hit_valid`, `hit_count` and clear; its outputs are `outstanding_zero` and the total.

## Test plan
Bench parameters: WIDTH=8, ROWS=4.
- Rows {0x10, 0x10, 0x00, 0x28}, `dp_ready`=1, each `hit_count` returned 2 cycles after acceptance as {0, 1, 0, 2} → `splitters_hit`=3, `done`=1, 4 handshakes, first `dp_valid` 3 cycles after `start`.
- Same grid with `dp_ready` low for 5 cycles on row 1 → `dp_row`=0x10 held stable throughout, total still 3, and the run is 5 cycles longer.
- `hit_valid` for row 1 coincident with the handshake of row 2 → outstanding stays correct and `done` follows the final response.
- `start` pulsed mid-run → ignored. `start` again after `done` → total clears to 0 and `done` drops; the rerun gives 3.
- `rst_n` low during ISSUE of row 2 → all outputs take their reset values asynchronously. A subsequent `start` gives a clean run with total 3.
- With `DAY7_SKIP_EMPTY_EN` → only 3 handshakes (row 2 skipped), total 3. Without the macro → 4 handshakes.
